sw_conditioner: RTL and testbench



---
 rtl/sw_cond_pkg.sv | 16 +
 rtl/debounce_bit.sv | 81 ++++++++
 rtl/sw_conditioner.sv | 37 +++
 tb/tb_sw_conditioner.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sw_cond_pkg.sv
// Shared switch-conditioning definitions used by sw_conditioner and the picoMIPS top.
// Defaults for bus width, synchroniser depth and debounce length live here.
package sw_cond_pkg;

  localparam int N_SW_DEF        = 10;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 16;

  typedef logic [N_SW_DEF-1:0] sw_bus_t;

  // Counter must hold 0..DB_CYCLES-1; keep at least one bit for DB_CYCLES=1.
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser + debounce filter + level register.
// Rising-edge pulse logic is built only when SW_COND_RISE_EN is defined.
module debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW      = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  generate
    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
      $fatal(1, "debounce_bit: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign level  = level_r;

  // Metastability synchroniser chain for the raw pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Any cycle of agreement restarts the count; the level flips only after DB_CYCLES disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
    end else if (sync_s != level_r) begin
      if (cnt_r == CNT_MAX) begin
        level_r <= sync_s;
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r   <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

`ifdef SW_COND_RISE_EN
  logic prev_r;
  logic rise_r;

  assign rise = rise_r;

  // Pulse one cycle after the debounced level goes 0->1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      prev_r <= level_r;
      rise_r <= level_r & ~prev_r;
    end
  end
`else
  assign rise = 1'b0;
`endif

endmodule

// File: rtl/sw_conditioner.sv
// Conditions the raw board switches into the clean SW bus for picoMIPS.
// Define SW_COND_RISE_EN to build the sw_rise edge pulses; otherwise sw_rise is held at zero.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int N_SW        = N_SW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] sw_rise
);

  generate
    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
      $fatal(1, "sw_conditioner: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
    end
  endgenerate

  // Each switch bit is filtered independently.
  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_debounce_bit (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[i]),
      .level (SW[i]),
      .rise  (sw_rise[i])
    );
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed self-checking bench for sw_conditioner with SYNC_STAGES=2, DB_CYCLES=4.
// Expected sw_rise follows whether SW_COND_RISE_EN is defined for this build.
module tb_sw_conditioner;

`ifdef SW_COND_RISE_EN
  localparam bit RISE_ON = 1'b1;
`else
  localparam bit RISE_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] sw_out;
  logic [9:0] sw_rise;

  int checks_cnt;
  int errors_cnt;

  sw_conditioner #(
    .N_SW        (10),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .SW      (sw_out),
    .sw_rise (sw_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [9:0] rise_exp(input logic [9:0] bits);
    return RISE_ON ? bits : 10'h000;
  endfunction

  // Walk n edges after a stimulus change: SW becomes base|chg from edge 6, rise pulses on edge 7.
  task automatic run_change(input string tag, input int n, input logic [9:0] before_v,
                            input logic [9:0] after_v, input logic [9:0] rise_bits);
    for (int k = 1; k <= n; k++) begin
      step();
      check_eq($sformatf("%s_sw_e%0d", tag, k), {22'd0, sw_out}, {22'd0, (k >= 6) ? after_v : before_v});
      check_eq($sformatf("%s_rise_e%0d", tag, k), {22'd0, sw_rise},
               {22'd0, (k == 7) ? rise_exp(rise_bits) : 10'h000});
    end
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset  = 1'b1;
    sw_raw = 10'h3FF;
    #1;
    check_eq("reset_sw_now", {22'd0, sw_out}, 32'h0);
    check_eq("reset_rise_now", {22'd0, sw_rise}, 32'h0);
    step(); step(); step();
    check_eq("reset_sw_held", {22'd0, sw_out}, 32'h0);
    check_eq("reset_rise_held", {22'd0, sw_rise}, 32'h0);

    // Release with all switches low and let everything settle.
    sw_raw = 10'h000;
    reset  = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_eq("idle_sw", {22'd0, sw_out}, 32'h0);

    // Bit 0 rises and stays high.
    sw_raw = 10'h001;
    run_change("b0", 8, 10'h000, 10'h001, 10'h001);

    // Bit 3 pulse of 3 cycles is filtered out.
    sw_raw = 10'h009;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq($sformatf("glitch_hi_sw_e%0d", k), {22'd0, sw_out}, 32'h001);
    end
    sw_raw = 10'h001;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq($sformatf("glitch_lo_sw_e%0d", k), {22'd0, sw_out}, 32'h001);
      check_eq($sformatf("glitch_lo_rise_e%0d", k), {22'd0, sw_rise}, 32'h000);
    end

    // Bit 8 bounces 1,0,1,1,... ; SW[8] rises on edge 8 of the pattern, pulse on edge 9.
    for (int k = 1; k <= 11; k++) begin
      sw_raw = (k == 2) ? 10'h001 : 10'h101;
      step();
      check_eq($sformatf("bounce_sw_e%0d", k), {22'd0, sw_out}, {22'd0, (k >= 8) ? 10'h101 : 10'h001});
      check_eq($sformatf("bounce_rise_e%0d", k), {22'd0, sw_rise},
               {22'd0, (k == 9) ? rise_exp(10'h100) : 10'h000});
    end

    // Bit 5 raised, then reset asserted mid-cycle after 3 edges.
    sw_raw = 10'h121;
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_sw_now", {22'd0, sw_out}, 32'h0);
    check_eq("midreset_rise_now", {22'd0, sw_rise}, 32'h0);
    step(); step();
    check_eq("midreset_sw_held", {22'd0, sw_out}, 32'h0);
    reset = 1'b0;
    run_change("postreset", 9, 10'h000, 10'h121, 10'h121);

    // Clear everything, then all ten bits rise together and fall together.
    reset  = 1'b1;
    sw_raw = 10'h000;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check_eq("all_idle_sw", {22'd0, sw_out}, 32'h0);
    sw_raw = 10'h3FF;
    run_change("all_rise", 9, 10'h000, 10'h3FF, 10'h3FF);
    sw_raw = 10'h000;
    run_change("all_fall", 9, 10'h3FF, 10'h000, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
